sync_fifo_fwft_prog: RTL and testbench

//  Next-generation synchronous FWFT FIFO: any DEPTH >= 2 (power of two not required), exact

---
 rtl/sync_fifo_fwft_prog_pkg.sv | 21 ++
 rtl/sync_fifo_fwft_prog_if.sv | 65 ++++++
 rtl/sync_fifo_fwft_prog_sdp_ram.sv | 35 +++
 rtl/sync_fifo_fwft_prog.sv | 145 ++++++++++++++
 tb/tb_sync_fifo_fwft_prog.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_fwft_prog_pkg.sv
// Shared types and sizing helpers for the programmable first-word-fall-through FIFO.
// Imported by the interface, the RAM and the FIFO top.
package sync_fifo_pkg;

    // Occupancy width: must be able to represent 0..depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Address width for a storage array of 'depth' entries; never narrower than one bit.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [1:0] {
        FIFO_OK,
        FIFO_OVF,
        FIFO_UDF
    } fifo_err_e;

endpackage

// File: rtl/sync_fifo_fwft_prog_if.sv
// Bus bundle between a FIFO and whatever drives it (producer, consumer and telemetry).
// The master modport is the driving side; the slave modport is the FIFO.
interface sync_fifo_fwft_prog_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1000
) ();

    localparam int CNT_W = fifo_cnt_w(DEPTH);

    // Handshake: a write is taken on a rising edge when i_wr_en=1 and o_full=0.
    // A pop is taken on a rising edge when i_rd_en=1 and o_empty=0.
    // o_empty acts as an inverted valid for o_rd_data, and o_full acts as an inverted ready.
    // Requests made against the wrong flag are dropped and raise the sticky error bits.
    logic                  i_clr;
    logic                  i_wr_en;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  o_full;
    logic                  i_rd_en;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_empty;
    logic [CNT_W-1:0]      i_afull_thr;
    logic [CNT_W-1:0]      i_aempty_thr;
    logic                  o_afull;
    logic                  o_aempty;
    logic [CNT_W-1:0]      o_count;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_clr,
        output i_wr_en,
        output i_wr_data,
        output i_rd_en,
        output i_afull_thr,
        output i_aempty_thr,
        input  o_full,
        input  o_rd_data,
        input  o_empty,
        input  o_afull,
        input  o_aempty,
        input  o_count,
        input  o_overflow,
        input  o_underflow
    );

    modport slave (
        input  i_clr,
        input  i_wr_en,
        input  i_wr_data,
        input  i_rd_en,
        input  i_afull_thr,
        input  i_aempty_thr,
        output o_full,
        output o_rd_data,
        output o_empty,
        output o_afull,
        output o_aempty,
        output o_count,
        output o_overflow,
        output o_underflow
    );

endinterface

// File: rtl/sync_fifo_fwft_prog_sdp_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
// The array has no reset, so synthesis can map it onto block RAM.
module sdp_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1000,
    parameter int ADDR_W     = fifo_ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The output register holds its value whenever re is low.
    // The FIFO relies on this, because the register doubles as its head word.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_fwft_prog.sv
// First-word-fall-through FIFO of exact capacity DEPTH, with a registered occupancy count,
// runtime almost-full/almost-empty thresholds, sticky error flags and a synchronous clear.
module sync_fifo_fwft_prog
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1000,
    parameter int CNT_W      = fifo_cnt_w(DEPTH)
) (
    input logic                 clk,
    input logic                 rst_n,
    sync_fifo_fwft_prog_if.slave bus
);

    localparam int               PTR_W    = fifo_ptr_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic                  head_from_ram_q;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  ovf_q;
    logic                  udf_q;

    logic full;
    logic empty;
    logic wr_ok;
    logic rd_ok;
    logic bypass;
    logic mem_we;
    logic prefetch;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // A clear cycle swallows both requests and cannot raise the error flags.
    assign wr_ok = bus.i_wr_en && !full  && !bus.i_clr;
    assign rd_ok = bus.i_rd_en && !empty && !bus.i_clr;

    // The head slot always holds the oldest word whenever count is nonzero.
    // The memory therefore holds count-1 words.
    // A write goes straight to the head if the head is free at this edge.
    // Otherwise the write goes into memory.
    assign bypass   = wr_ok && (empty || ((count_q == CNT_ONE) && rd_ok));
    assign mem_we   = wr_ok && !bypass;
    assign prefetch = rd_ok && (count_q > CNT_ONE);

    sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (bus.i_wr_data),
        .re    (prefetch),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (bus.i_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (mem_we) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (prefetch) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (bus.i_clr) begin
            count_d = '0;
        end else if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The head is either the bypass register or the RAM output register.
    // A clear leaves both registers and the select untouched, so o_rd_data holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q          <= '0;
            head_from_ram_q <= 1'b0;
        end else if (!bus.i_clr) begin
            if (bypass) begin
                head_q          <= bus.i_wr_data;
                head_from_ram_q <= 1'b0;
            end else if (prefetch) begin
                head_from_ram_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (bus.i_clr) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.i_wr_en && full) begin
                ovf_q <= 1'b1;
            end
            if (bus.i_rd_en && empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.o_rd_data   = head_from_ram_q ? ram_rdata : head_q;
    assign bus.o_count     = count_q;
    assign bus.o_full      = full;
    assign bus.o_empty     = empty;
    assign bus.o_afull     = (count_q >= bus.i_afull_thr);
    assign bus.o_aempty    = (count_q <= bus.i_aempty_thr);
    assign bus.o_overflow  = ovf_q;
    assign bus.o_underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo_fwft_prog.sv
// Bench for sync_fifo_fwft_prog: directed scenarios run on a DEPTH=5 instance,
// and a randomized stream runs on a DEPTH=7 instance checked against a queue model.
module tb_sync_fifo_fwft_prog;
    import sync_fifo_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [31:0] exp_q[$];

    sync_fifo_fwft_prog_if #(.DATA_WIDTH(32), .DEPTH(5)) b5 ();
    sync_fifo_fwft_prog_if #(.DATA_WIDTH(32), .DEPTH(7)) b7 ();

    sync_fifo_fwft_prog #(.DATA_WIDTH(32), .DEPTH(5)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b5)
    );

    sync_fifo_fwft_prog #(.DATA_WIDTH(32), .DEPTH(7)) u_dut7 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b7)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle5();
        b5.i_clr     = 1'b0;
        b5.i_wr_en   = 1'b0;
        b5.i_rd_en   = 1'b0;
        b5.i_wr_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle5();
        b5.i_afull_thr  = 3'd4;
        b5.i_aempty_thr = 3'd1;
        b7.i_clr = 1'b0; b7.i_wr_en = 1'b0; b7.i_rd_en = 1'b0; b7.i_wr_data = '0;
        b7.i_afull_thr = 3'd6; b7.i_aempty_thr = 3'd1;
        #7;
        checks++; if (b5.o_count !== 3'd0)    begin errors++; $display("FAIL por_count got=%0d exp=0", b5.o_count); end
        checks++; if (b5.o_empty !== 1'b1)    begin errors++; $display("FAIL por_empty got=%b exp=1", b5.o_empty); end
        checks++; if (b5.o_full !== 1'b0)     begin errors++; $display("FAIL por_full got=%b exp=0", b5.o_full); end
        checks++; if (b5.o_rd_data !== 32'h0) begin errors++; $display("FAIL por_rd_data got=%h exp=0", b5.o_rd_data); end
        checks++; if (b5.o_overflow !== 1'b0 || b5.o_underflow !== 1'b0) begin
            errors++; $display("FAIL por_errs got=%b%b exp=00", b5.o_overflow, b5.o_underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // mid-stream reset with 5 words held
        for (int i = 0; i < 5; i++) begin
            b5.i_wr_en = 1'b1; b5.i_wr_data = 32'h11 + 32'(i);
            tick();
        end
        idle5();
        checks++; if (b5.o_count !== 3'd5) begin errors++; $display("FAIL mid_pre_count got=%0d exp=5", b5.o_count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (b5.o_count !== 3'd0)    begin errors++; $display("FAIL mid_count got=%0d exp=0", b5.o_count); end
        checks++; if (b5.o_empty !== 1'b1 || b5.o_full !== 1'b0) begin
            errors++; $display("FAIL mid_flags got empty=%b full=%b exp 1/0", b5.o_empty, b5.o_full);
        end
        checks++; if (b5.o_rd_data !== 32'h0) begin errors++; $display("FAIL mid_rd_data got=%h exp=0", b5.o_rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (b5.o_count !== 3'd0) begin errors++; $display("FAIL rel_count got=%0d exp=0", b5.o_count); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 5; i++) begin
            checks++; if (b5.o_full !== 1'b0) begin errors++; $display("FAIL fill_full_early%0d got=%b exp=0", i, b5.o_full); end
            b5.i_wr_en = 1'b1; b5.i_wr_data = 32'(i);
            tick();
        end
        checks++; if (b5.o_full !== 1'b1)  begin errors++; $display("FAIL fill_full got=%b exp=1", b5.o_full); end
        checks++; if (b5.o_count !== 3'd5) begin errors++; $display("FAIL fill_count got=%0d exp=5", b5.o_count); end
        b5.i_wr_data = 32'd6;
        tick();
        idle5();
        checks++; if (b5.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", b5.o_overflow); end
        checks++; if (b5.o_count !== 3'd5)    begin errors++; $display("FAIL ovf_count got=%0d exp=5", b5.o_count); end
        for (int i = 1; i <= 5; i++) begin
            checks++; if (b5.o_rd_data !== 32'(i)) begin errors++; $display("FAIL drain_data%0d got=%0d exp=%0d", i, b5.o_rd_data, i); end
            b5.i_rd_en = 1'b1;
            tick();
        end
        idle5();
        checks++; if (b5.o_empty !== 1'b1 || b5.o_count !== 3'd0) begin
            errors++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", b5.o_empty, b5.o_count);
        end
        checks++; if (b5.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", b5.o_overflow); end
        b5.i_clr = 1'b1;
        tick();
        idle5();
        checks++; if (b5.o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", b5.o_overflow); end
    endtask

    task automatic test_bypass();
        b5.i_wr_en = 1'b1; b5.i_wr_data = 32'hA5;
        tick();
        checks++; if (b5.o_empty !== 1'b0)     begin errors++; $display("FAIL byp_empty got=%b exp=0", b5.o_empty); end
        checks++; if (b5.o_rd_data !== 32'hA5) begin errors++; $display("FAIL byp_data got=%h exp=a5", b5.o_rd_data); end
        b5.i_wr_data = 32'hB6; b5.i_rd_en = 1'b1;
        tick();
        checks++; if (b5.o_rd_data !== 32'hB6) begin errors++; $display("FAIL byp_swap_data got=%h exp=b6", b5.o_rd_data); end
        checks++; if (b5.o_count !== 3'd1)     begin errors++; $display("FAIL byp_swap_count got=%0d exp=1", b5.o_count); end
        b5.i_wr_en = 1'b0;
        tick();
        idle5();
        checks++; if (b5.o_empty !== 1'b1 || b5.o_underflow !== 1'b0) begin
            errors++; $display("FAIL byp_end got empty=%b udf=%b exp 1/0", b5.o_empty, b5.o_underflow);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            b5.i_wr_en = 1'b1; b5.i_wr_data = 32'h200 + 32'(i);
            exp_q.push_back(32'h200 + 32'(i));
            tick();
        end
        for (int k = 0; k < 9; k++) begin
            checks++; if (b5.o_rd_data !== exp_q[0]) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", k, b5.o_rd_data, exp_q[0]); end
            checks++; if (b5.o_count !== 3'd3)       begin errors++; $display("FAIL b2b_count%0d got=%0d exp=3", k, b5.o_count); end
            b5.i_wr_en = 1'b1; b5.i_rd_en = 1'b1; b5.i_wr_data = 32'h300 + 32'(k);
            void'(exp_q.pop_front());
            exp_q.push_back(32'h300 + 32'(k));
            tick();
        end
        b5.i_wr_en = 1'b0;
        while (exp_q.size() > 0) begin
            checks++; if (b5.o_rd_data !== exp_q[0]) begin errors++; $display("FAIL b2b_drain got=%h exp=%h", b5.o_rd_data, exp_q[0]); end
            b5.i_rd_en = 1'b1;
            void'(exp_q.pop_front());
            tick();
        end
        idle5();
        checks++; if (b5.o_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", b5.o_empty); end
    endtask

    task automatic test_thresholds();
        logic [4:0] afull_exp;
        logic [4:0] aempty_exp;
        afull_exp  = 5'b11000;
        aempty_exp = 5'b00011;
        b5.i_afull_thr  = 3'd3;
        b5.i_aempty_thr = 3'd1;
        #1;
        for (int c = 0; c <= 4; c++) begin
            checks++; if (b5.o_afull !== afull_exp[c])   begin errors++; $display("FAIL thr_afull_c%0d got=%b exp=%b", c, b5.o_afull, afull_exp[c]); end
            checks++; if (b5.o_aempty !== aempty_exp[c]) begin errors++; $display("FAIL thr_aempty_c%0d got=%b exp=%b", c, b5.o_aempty, aempty_exp[c]); end
            if (c < 4) begin
                b5.i_wr_en = 1'b1; b5.i_wr_data = 32'h40 + 32'(c);
                tick();
            end
        end
        idle5();
        b5.i_afull_thr = 3'd5;
        #1;
        checks++; if (b5.o_afull !== 1'b0) begin errors++; $display("FAIL thr_afull_raise got=%b exp=0", b5.o_afull); end
        b5.i_aempty_thr = 3'd5;
        #1;
        checks++; if (b5.o_aempty !== 1'b1) begin errors++; $display("FAIL thr_aempty_depth got=%b exp=1", b5.o_aempty); end
        b5.i_aempty_thr = 3'd3;
        #1;
        checks++; if (b5.o_aempty !== 1'b0) begin errors++; $display("FAIL thr_aempty_3 got=%b exp=0", b5.o_aempty); end
        b5.i_clr = 1'b1;
        tick();
        idle5();
        b5.i_afull_thr  = 3'd0;
        b5.i_aempty_thr = 3'd7;
        #1;
        checks++; if (b5.o_afull !== 1'b1)  begin errors++; $display("FAIL thr_afull_zero got=%b exp=1", b5.o_afull); end
        checks++; if (b5.o_aempty !== 1'b1) begin errors++; $display("FAIL thr_aempty_max got=%b exp=1", b5.o_aempty); end
        b5.i_afull_thr  = 3'd4;
        b5.i_aempty_thr = 3'd1;
    endtask

    task automatic test_errors();
        b5.i_rd_en = 1'b1;
        tick();
        b5.i_rd_en = 1'b0;
        checks++; if (b5.o_underflow !== 1'b1) begin errors++; $display("FAIL udf_flag got=%b exp=1", b5.o_underflow); end
        checks++; if (b5.o_count !== 3'd0)     begin errors++; $display("FAIL udf_count got=%0d exp=0", b5.o_count); end
        b5.i_wr_en = 1'b1; b5.i_wr_data = 32'h5A;
        tick();
        checks++; if (b5.o_rd_data !== 32'h5A) begin errors++; $display("FAIL pre_clr_data got=%h exp=5a", b5.o_rd_data); end
        b5.i_clr = 1'b1; b5.i_wr_data = 32'h77; b5.i_rd_en = 1'b1;
        tick();
        idle5();
        checks++; if (b5.o_count !== 3'd0)     begin errors++; $display("FAIL clr_count got=%0d exp=0", b5.o_count); end
        checks++; if (b5.o_underflow !== 1'b0 || b5.o_overflow !== 1'b0) begin
            errors++; $display("FAIL clr_errs got ovf=%b udf=%b exp 0/0", b5.o_overflow, b5.o_underflow);
        end
        checks++; if (b5.o_rd_data !== 32'h5A) begin errors++; $display("FAIL clr_hold_data got=%h exp=5a", b5.o_rd_data); end
        tick();
        checks++; if (b5.o_empty !== 1'b1 || b5.o_count !== 3'd0) begin
            errors++; $display("FAIL clr_no_write got empty=%b count=%0d exp 1/0", b5.o_empty, b5.o_count);
        end
    endtask

    task automatic test_random();
        logic      m_ovf;
        logic      m_udf;
        logic      wr;
        logic      rd;
        logic      clr;
        int        wr_pct;
        int        rd_pct;
        int        sz;
        fifo_err_e ev;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            b7.i_afull_thr  = 3'($urandom_range(0, 7));
            b7.i_aempty_thr = 3'($urandom_range(0, 7));
            #1;
            sz = exp_q.size();
            checks++; if (b7.o_count !== 3'(sz)) begin errors++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", cyc, b7.o_count, sz); end
            checks++; if (b7.o_empty !== (sz == 0) || b7.o_full !== (sz == 7)) begin
                errors++; $display("FAIL rnd_flags c%0d got empty=%b full=%b size=%0d", cyc, b7.o_empty, b7.o_full, sz);
            end
            checks++; if (b7.o_afull !== (sz >= int'(b7.i_afull_thr)) || b7.o_aempty !== (sz <= int'(b7.i_aempty_thr))) begin
                errors++; $display("FAIL rnd_thr c%0d got afull=%b aempty=%b size=%0d", cyc, b7.o_afull, b7.o_aempty, sz);
            end
            checks++; if (b7.o_overflow !== m_ovf || b7.o_underflow !== m_udf) begin
                errors++; $display("FAIL rnd_errs c%0d got=%b%b exp=%b%b", cyc, b7.o_overflow, b7.o_underflow, m_ovf, m_udf);
            end
            if (sz > 0) begin
                checks++; if (b7.o_rd_data !== exp_q[0]) begin errors++; $display("FAIL rnd_data c%0d got=%h exp=%h", cyc, b7.o_rd_data, exp_q[0]); end
            end
            wr_pct = ((cyc / 400) % 2 == 0) ? 75 : 35;
            rd_pct = 110 - wr_pct;
            wr  = ($urandom_range(0, 99) < wr_pct);
            rd  = ($urandom_range(0, 99) < rd_pct);
            clr = ($urandom_range(0, 199) == 0);
            b7.i_wr_en   = wr;
            b7.i_rd_en   = rd;
            b7.i_clr     = clr;
            b7.i_wr_data = $urandom;
            ev = FIFO_OK;
            if (clr) begin
                exp_q.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                if (wr && sz == 7) ev = FIFO_OVF;
                if (rd && sz == 0) ev = FIFO_UDF;
                if (ev == FIFO_OVF) m_ovf = 1'b1;
                if (ev == FIFO_UDF) m_udf = 1'b1;
                if (rd && sz > 0) void'(exp_q.pop_front());
                if (wr && sz < 7) exp_q.push_back(b7.i_wr_data);
            end
            tick();
        end
        b7.i_wr_en = 1'b0; b7.i_rd_en = 1'b0; b7.i_clr = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fill_overflow();
        test_bypass();
        test_back_to_back();
        test_thresholds();
        test_errors();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
